// File: rtl/riscv_pkg.sv
// Shared RV32I load/store width codes and responder FSM states.
// The core imports the same constants.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores
    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return ~lo[0];
            2'b10:   return lo == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Fetch and data-port signals between the core (master) and the memory responder (slave).
interface riscv_mem_responder_if;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        i_valid;
    logic        d_req;
    logic        d_ready;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_fault;

    modport slave (
        input  i_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
        output i_data, i_valid, d_ready, d_rdata, d_rvalid, d_fault
    );

    modport master (
        output i_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
        input  i_data, i_valid, d_ready, d_rdata, d_rvalid, d_fault
    );
endinterface

// File: rtl/riscv_load_align.sv
// Byte-lane steering: load lane select with sign/zero extension, and the
// store byte-enable plus replicated write-data lanes.
module riscv_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] wlanes_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word_i >> {addr_lo_i, 3'b000};
        case (funct3_i)
            F3_LB:   rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  rdata_o = {24'b0, shifted[7:0]};
            F3_LHU:  rdata_o = {16'b0, shifted[15:0]};
            default: rdata_o = word_i;
        endcase
    end

    // Replicating the data across lanes lets the byte-enable alone pick the target
    always_comb begin
        case (funct3_i[1:0])
            2'b00: begin
                be_o     = 4'b0001 << addr_lo_i;
                wlanes_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wlanes_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o     = 4'b1111;
                wlanes_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/riscv_mem_responder.sv
// Word-organised little-endian RAM serving a registered fetch port and a
// req/ready/rvalid data port with alignment, funct3 and range faulting.
module riscv_mem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_mem_responder_if.slave  bus
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [2:0] LAT_M1 = 3'(RD_LATENCY - 1);

    logic [31:0]   mem_q [DEPTH_WORDS];
    state_e        state_q;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    cnt_q;
    logic [31:0]   i_data_q;
    logic          i_valid_q;
    logic          d_ready_q;
    logic [31:0]   d_rdata_q;
    logic          d_rvalid_q;
    logic          d_fault_q;

    logic          idle;
    logic          sel_we;
    logic [2:0]    sel_f3;
    logic [AW+1:0] sel_addr;
    logic [31:0]   rd_word;
    logic [31:0]   al_rdata;
    logic [31:0]   al_wlanes;
    logic [3:0]    al_be;
    logic [31:0]   load_data;
    logic          req_ok;

    // In IDLE the request fields are still on the bus; afterwards use the latched copy
    assign idle      = (state_q == ST_IDLE);
    assign sel_we    = idle ? bus.d_we : we_q;
    assign sel_f3    = idle ? bus.d_funct3 : funct3_q;
    assign sel_addr  = idle ? bus.d_addr[AW+1:0] : addr_q;
    assign rd_word   = mem_q[sel_addr[AW+1:2]];
    assign load_data = sel_we ? 32'b0 : al_rdata;

    assign req_ok = funct3_legal(bus.d_we, bus.d_funct3) &&
                    addr_aligned(bus.d_funct3, bus.d_addr[1:0]) &&
                    (bus.d_addr[31:2] < 30'(DEPTH_WORDS));

    riscv_load_align u_align (
        .word_i    (rd_word),
        .addr_lo_i (sel_addr[1:0]),
        .funct3_i  (sel_f3),
        .wdata_i   (wdata_q),
        .rdata_o   (al_rdata),
        .be_o      (al_be),
        .wlanes_o  (al_wlanes)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            i_data_q  <= '0;
            i_valid_q <= 1'b0;
        end else if (bus.i_addr < 32'(DEPTH_WORDS)) begin
            i_data_q  <= mem_q[bus.i_addr[AW-1:0]];
            i_valid_q <= 1'b1;
        end else begin
            i_data_q  <= '0;
            i_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_RESP && we_q) begin
            for (int b = 0; b < 4; b++) begin
                if (al_be[b]) begin
                    mem_q[addr_q[AW+1:2]][b*8 +: 8] <= al_wlanes[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            d_ready_q  <= 1'b1;
            d_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
            d_fault_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.d_req) begin
                        we_q      <= bus.d_we;
                        funct3_q  <= bus.d_funct3;
                        addr_q    <= bus.d_addr[AW+1:0];
                        wdata_q   <= bus.d_wdata;
                        d_ready_q <= 1'b0;
                        if (!req_ok) begin
                            state_q    <= ST_FAULT;
                            d_rvalid_q <= 1'b1;
                            d_fault_q  <= 1'b1;
                            d_rdata_q  <= '0;
                        end else if (RD_LATENCY > 0) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= LAT_M1;
                        end else begin
                            state_q    <= ST_RESP;
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= load_data;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q    <= ST_RESP;
                        d_rvalid_q <= 1'b1;
                        d_rdata_q  <= load_data;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_RESP: begin
                    state_q    <= ST_IDLE;
                    d_rvalid_q <= 1'b0;
                    d_rdata_q  <= '0;
                    d_ready_q  <= 1'b1;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    d_rvalid_q <= 1'b0;
                    d_fault_q  <= 1'b0;
                    d_rdata_q  <= '0;
                    d_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.i_data   = i_data_q;
    assign bus.i_valid  = i_valid_q;
    assign bus.d_ready  = d_ready_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.d_fault  = d_fault_q;

endmodule
